// File: rtl/sarray_storec_wb.sv
// STOREC writeback stage: requests a post-storec drain from the systolic array,
// buffers the bottom-edge result rows and streams them out as address/data writes.
module sarray_storec_wb #(
  parameter int ADDR_WIDTH   = 64,
  parameter int ROW_WIDTH    = 512,
  parameter int ROWS         = 16,
  parameter int STRIDE_SHIFT = 8,
  localparam int IDX_W       = $clog2(ROWS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  output logic                  drain_req_o,
  input  logic                  row_valid_i,
  input  logic [IDX_W-1:0]      row_idx_i,
  input  logic [ROW_WIDTH-1:0]  row_data_i,
  output logic                  aw_valid_o,
  input  logic                  aw_ready_i,
  output logic [ADDR_WIDTH-1:0] aw_addr_o,
  output logic [ROW_WIDTH-1:0]  aw_data_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; aw_valid_o/aw_addr_o/aw_data_o never change while valid is waiting for ready.
  typedef enum logic [1:0] {S_IDLE, S_START, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [IDX_W:0]        r_rx_cnt;
  logic [IDX_W:0]        r_tx_cnt;
  logic [IDX_W:0]        r_wr_ptr;
  logic [IDX_W:0]        r_rd_ptr;
  logic [IDX_W-1:0]      r_mem_idx  [ROWS];
  logic [ROW_WIDTH-1:0]  r_mem_data [ROWS];
  logic                  r_err;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_aw_valid;
  logic                  w_pop;
  logic                  w_rx_open;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_accept;
  logic                  w_last;
  logic [IDX_W-1:0]      w_head_idx;
  logic [ADDR_WIDTH-1:0] w_head_addr;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                      (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
  assign w_aw_valid = (r_state == S_DRAIN) && !w_empty;
  assign w_pop      = w_aw_valid && aw_ready_i;
  assign w_rx_open  = (r_state == S_START) || (r_state == S_DRAIN);
  // A full FIFO still takes a row when the head leaves in the same cycle.
  assign w_push     = row_valid_i && w_rx_open && (r_rx_cnt < (IDX_W+1)'(ROWS)) &&
                      (!w_full || w_pop);
  assign w_drop     = row_valid_i && !w_push;
  assign w_accept   = (r_state == S_IDLE) && cmd_valid_i;
  assign w_last     = w_pop && (r_tx_cnt == (IDX_W+1)'(ROWS - 1));

  assign w_head_idx  = r_mem_idx[r_rd_ptr[IDX_W-1:0]];
  assign w_head_addr = r_base + (ADDR_WIDTH'(w_head_idx) << STRIDE_SHIFT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_START;
      S_START: w_next = S_DRAIN;
      S_DRAIN: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_rx_cnt <= '0;
      r_tx_cnt <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_base   <= cmd_addr_i;
        r_rx_cnt <= '0;
        r_tx_cnt <= '0;
      end else begin
        if (w_push) r_rx_cnt <= r_rx_cnt + 1'b1;
        if (w_pop)  r_tx_cnt <= r_tx_cnt + 1'b1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) r_err <= 1'b1;
    end
  end

  // Row storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_idx[r_wr_ptr[IDX_W-1:0]]  <= row_idx_i;
      r_mem_data[r_wr_ptr[IDX_W-1:0]] <= row_data_i;
    end
  end

  assign cmd_ready_o = (r_state == S_IDLE) && rst_n;
  assign drain_req_o = (r_state == S_START);
  assign done_o      = (r_state == S_DONE);
  assign aw_valid_o  = w_aw_valid;
  assign aw_addr_o   = w_aw_valid ? w_head_addr : '0;
  assign aw_data_o   = w_aw_valid ? r_mem_data[r_rd_ptr[IDX_W-1:0]] : '0;
  assign err_o       = r_err;
  assign state_o     = r_state;

endmodule

// File: tb/tb_sarray_storec_wb.sv
// Randomized bench for sarray_storec_wb: a queue-based reference model is compared
// against every DUT output each cycle, plus literal checks on known address patterns.
module tb_sarray_storec_wb;
  localparam int AW = 64;
  localparam int RW = 512;
  localparam int IW = 4;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_addr_i = '0;
  logic          drain_req_o;
  logic          row_valid_i = 1'b0;
  logic [IW-1:0] row_idx_i = '0;
  logic [RW-1:0] row_data_i = '0;
  logic          aw_valid_o;
  logic          aw_ready_i = 1'b0;
  logic [AW-1:0] aw_addr_o;
  logic [RW-1:0] aw_data_o;
  logic          done_o;
  logic          err_o;
  logic [1:0]    state_o;

  sarray_storec_wb dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .drain_req_o(drain_req_o),
    .row_valid_i(row_valid_i), .row_idx_i(row_idx_i), .row_data_i(row_data_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .aw_addr_o(aw_addr_o), .aw_data_o(aw_data_o),
    .done_o(done_o), .err_o(err_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  // reference model: phase 0=idle 1=start 2=drain 3=done, FIFO as a queue
  logic [IW+RW-1:0] exp_q[$];
  int            m_phase = 0;
  int            m_rx = 0;
  int            m_tx = 0;
  logic          m_err = 1'b0;
  logic [AW-1:0] m_base = '0;

  logic [AW-1:0] hs_addr[$];
  int            drain_cnt = 0;
  int            done_cnt = 0;
  int            cyc = 0;
  int            acc_cyc = 0;
  int            done_cyc = 0;

  logic             e_awv;
  logic             e_pop;
  logic             e_push;
  logic [IW+RW-1:0] e_head;
  logic [AW-1:0]    e_addr;
  logic [RW-1:0]    e_data;

  // scoreboard / compare process
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_phase = 0; m_rx = 0; m_tx = 0; m_err = 1'b0;
      exp_q.delete();
    end
    e_awv  = (m_phase == 2) && (exp_q.size() > 0);
    e_head = e_awv ? exp_q[0] : '0;
    e_addr = e_awv ? m_base + 64'(e_head[RW +: IW]) * 64'd256 : '0;
    e_data = e_awv ? e_head[RW-1:0] : '0;
    chk("cmd_ready", RW'(cmd_ready_o), RW'(m_phase == 0 && rst_n));
    chk("drain_req", RW'(drain_req_o), RW'(m_phase == 1));
    chk("aw_valid", RW'(aw_valid_o), RW'(e_awv));
    chk("aw_addr", RW'(aw_addr_o), RW'(e_addr));
    chk("aw_data", aw_data_o, e_data);
    chk("done", RW'(done_o), RW'(m_phase == 3));
    chk("err", RW'(err_o), RW'(m_err));
    chk("state", RW'(state_o), RW'(m_phase));

    if (rst_n) begin
      if (aw_valid_o && aw_ready_i) hs_addr.push_back(aw_addr_o);
      if (drain_req_o) drain_cnt++;
      if (done_o) begin done_cnt++; done_cyc = cyc; end
      if (cmd_valid_i && cmd_ready_o) acc_cyc = cyc;

      e_pop  = e_awv && aw_ready_i;
      e_push = row_valid_i && (m_phase == 1 || m_phase == 2) && (m_rx < NR) &&
               (exp_q.size() < NR || e_pop);
      if (row_valid_i && !e_push) m_err = 1'b1;
      if (e_pop) void'(exp_q.pop_front());
      if (e_push) begin
        exp_q.push_back({row_idx_i, row_data_i});
        m_rx++;
      end
      case (m_phase)
        0: if (cmd_valid_i) begin
             m_base = cmd_addr_i; m_rx = 0; m_tx = 0; m_phase = 1;
           end
        1: m_phase = 2;
        2: if (e_pop) begin
             if (m_tx == NR - 1) m_phase = 3;
             m_tx++;
           end
        default: m_phase = 0;
      endcase
    end
  end

  // aw_ready driver: 0 = always ready, 1 = random, 2 = stalled
  int rdy_mode = 0;
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: aw_ready_i = 1'b1;
      1: aw_ready_i = 1'($urandom_range(0, 1));
      default: aw_ready_i = 1'b0;
    endcase
  end

  // driver tasks
  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_cmd(input logic [AW-1:0] a);
    int n = 0;
    @(posedge clk); #1;
    cmd_valid_i = 1'b1;
    cmd_addr_i  = a;
    forever begin
      @(negedge clk);
      if (cmd_ready_o) break;
      n++;
      if (n > 400) begin timeout_fail("cmd_accept"); break; end
    end
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  // order: 0 ascending, 1 descending, 2 random, 3 rotated by one (1..15,0)
  task automatic send_rows(input int n, input int order, input bit gaps);
    for (int i = 0; i < n; i++) begin
      row_valid_i = 1'b1;
      case (order)
        0: row_idx_i = IW'(i);
        1: row_idx_i = IW'(NR - 1 - i);
        2: row_idx_i = IW'($urandom_range(0, NR - 1));
        default: row_idx_i = IW'(i + 1);
      endcase
      row_data_i = rand_row();
      @(posedge clk); #1;
      row_valid_i = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_done(input int base_cnt);
    int n = 0;
    while (done_cnt <= base_cnt) begin
      @(negedge clk);
      n++;
      if (n > 600) begin timeout_fail("done_wait"); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int h0, d0, n0;

  initial begin
    #2;
    chk("reset_state", RW'(state_o), RW'(0));
    chk("reset_awv", RW'(aw_valid_o), RW'(0));
    chk("reset_cmd_ready", RW'(cmd_ready_o), RW'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // basic drain
    rdy_mode = 0;
    h0 = hs_addr.size(); d0 = drain_cnt; n0 = done_cnt;
    do_cmd(64'h1000);
    send_rows(NR, 0, 1'b0);
    wait_done(n0);
    for (int i = 0; i < NR; i++)
      chk("basic_addr", RW'(hs_addr[h0+i]), RW'(64'h1000 + 64'(i) * 64'h100));
    chk("basic_drain_pulses", RW'(drain_cnt - d0), RW'(1));
    chk("basic_done_pulses", RW'(done_cnt - n0), RW'(1));
    chk("basic_err", RW'(err_o), RW'(0));

    // backpressure: FIFO fills completely, then drains under random ready
    rdy_mode = 2;
    h0 = hs_addr.size(); n0 = done_cnt;
    do_cmd(64'h2000);
    send_rows(NR, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_writes", RW'(hs_addr.size() - h0), RW'(0));
    chk("bp_full_err", RW'(err_o), RW'(0));
    rdy_mode = 1;
    wait_done(n0);
    for (int i = 0; i < NR; i++)
      chk("bp_addr", RW'(hs_addr[h0+i]), RW'(64'h2000 + 64'(i) * 64'h100));
    chk("bp_err", RW'(err_o), RW'(0));

    // descending indices
    rdy_mode = 0;
    h0 = hs_addr.size(); n0 = done_cnt;
    do_cmd(64'h1000);
    send_rows(NR, 1, 1'b0);
    wait_done(n0);
    chk("desc_first", RW'(hs_addr[h0]), RW'(64'h1F00));
    chk("desc_last", RW'(hs_addr[h0+NR-1]), RW'(64'h1000));

    // row while idle
    h0 = hs_addr.size();
    @(posedge clk); #1;
    row_valid_i = 1'b1; row_idx_i = 4'd3; row_data_i = rand_row();
    @(posedge clk); #1;
    row_valid_i = 1'b0;
    @(negedge clk);
    chk("idle_row_err", RW'(err_o), RW'(1));
    chk("idle_row_no_aw", RW'(hs_addr.size() - h0), RW'(0));
    pulse_reset();

    // 17th row
    n0 = done_cnt;
    do_cmd(64'h3000);
    send_rows(NR + 1, 0, 1'b0);
    wait_done(n0);
    chk("extra_row_err", RW'(err_o), RW'(1));
    pulse_reset();

    // command hold-off, then address wrap
    rdy_mode = 1;
    n0 = done_cnt;
    do_cmd(64'h4000);
    fork
      send_rows(NR, 2, 1'b1);
      begin
        repeat (4) begin @(posedge clk); #1; end
        do_cmd(64'hFFFF_FFFF_FFFF_FF00);
      end
    join
    chk("holdoff_after_done", RW'(acc_cyc - done_cyc), RW'(1));
    chk("holdoff_one_done", RW'(done_cnt - n0), RW'(1));
    rdy_mode = 0;
    h0 = hs_addr.size(); n0 = done_cnt;
    send_rows(NR, 3, 1'b0);
    wait_done(n0);
    chk("wrap_addr0", RW'(hs_addr[h0]), RW'(64'h0));
    chk("wrap_addr1", RW'(hs_addr[h0+1]), RW'(64'h100));
    chk("wrap_last", RW'(hs_addr[h0+NR-1]), RW'(64'hFFFF_FFFF_FFFF_FF00));

    // reset mid-drain
    h0 = hs_addr.size(); n0 = done_cnt;
    do_cmd(64'h5000);
    send_rows(7, 0, 1'b0);
    begin
      int n = 0;
      while (hs_addr.size() - h0 < 5) begin
        @(posedge clk); #1;
        n++;
        if (n > 50) begin timeout_fail("mid_writes"); break; end
      end
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", RW'(state_o), RW'(0));
    chk("mid_rst_awv", RW'(aw_valid_o), RW'(0));
    chk("mid_rst_addr", RW'(aw_addr_o), RW'(0));
    chk("mid_rst_done", RW'(done_o), RW'(0));
    chk("mid_rst_cmd_ready", RW'(cmd_ready_o), RW'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mid_rst_no_done", RW'(done_cnt - n0), RW'(0));
    rdy_mode = 1;
    h0 = hs_addr.size(); n0 = done_cnt;
    do_cmd(64'h6000);
    send_rows(NR, 2, 1'b1);
    wait_done(n0);
    chk("fresh_count", RW'(hs_addr.size() - h0), RW'(NR));
    chk("fresh_err", RW'(err_o), RW'(0));

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sarray_storec_wb.md
Name: sarray_storec_wb

Overview:
- Writeback stage directly downstream of the systolic-array top. It accepts a STOREC command and pulses the array's post-storec drain request.
- It captures the result rows emitted at the array's bottom edge into a row FIFO and streams them out on the AW write channel, one row per handshake.
- Row addresses are base + row_index*stride. A done pulse is issued when the last row has been written.

Parameters:
- ADDR_WIDTH, 64, address width.
- ROW_WIDTH, 512, bits per result row (SARRAY_STORE_WIDTH).
- ROWS, 16, rows per tile (SARRAY_H); power of 2.
- STRIDE_SHIFT, 8, log2 of the byte stride between rows.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  STOREC command valid.
- cmd_ready_o  out  1  command accepted when high with valid.
- cmd_addr_i  in  ADDR_WIDTH  destination base address.
- drain_req_o  out  1  one-cycle pulse to the array's post_storec_valid_i.
- row_valid_i  in  1  bottom-edge row valid; no backpressure.
- row_idx_i  in  log2(ROWS)  row index of the incoming row.
- row_data_i  in  ROW_WIDTH  row data.
- aw_valid_o  out  1  write request valid.
- aw_ready_i  in  1  write request ready.
- aw_addr_o  out  ADDR_WIDTH  write address.
- aw_data_o  out  ROW_WIDTH  write data.
- done_o  out  1  one-cycle pulse after the final AW handshake.
- err_o  out  1  sticky protocol error flag.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; FIFO empty.
  - Counters (rx_cnt, tx_cnt) 0; err_o 0.
- States: IDLE, START, DRAIN, DONE.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i: latch base ← cmd_addr_i, clear rx_cnt and tx_cnt, go to START.
- START:
  - drain_req_o=1 for exactly this one cycle, then go to DRAIN.
  - A row arriving in START is accepted, exactly as in DRAIN.
- DRAIN: rows are pushed and popped concurrently.
- Push rules:
  - Push on row_valid_i when in START or DRAIN and rx_cnt<ROWS.
  - Each push writes {row_idx_i, row_data_i} to the FIFO tail and increments rx_cnt.
- FIFO: depth ROWS, registered storage, circular pointers of log2(ROWS)+1 bits.
  - empty when the pointers are equal.
  - full when the pointers differ only in the MSB.
- Pop rules:
  - aw_valid_o = (state==DRAIN) & ~empty.
  - aw_addr_o = base + (head.idx << STRIDE_SHIFT), computed modulo 2^ADDR_WIDTH.
  - aw_data_o = head.data.
  - Once asserted, aw_valid/addr/data hold stable until aw_ready_i.
  - On handshake: pop the head, increment tx_cnt.
- Simultaneous push and pop in one cycle is legal. Occupancy is unchanged, and a push into a full FIFO is legal when a pop happens in the same cycle.
- Transitions out of DRAIN:
  - When the handshake with tx_cnt==ROWS-1 completes, go to DONE.
  - DONE: done_o=1 for one cycle, then go to IDLE.
- cmd_ready_o=0 in every state except IDLE. A command arriving while busy is held off, not lost.
- err_o set (sticky until reset) when any of these occurs:
  - row_valid_i while in IDLE or DONE; the row is dropped.
  - row_valid_i with rx_cnt==ROWS; the row is dropped.
  - row_valid_i while the FIFO is full and no pop happens that cycle; the row is dropped.
- Row indices are not checked for uniqueness. Output order equals arrival order.
- Reset asserted mid-operation: immediately return to IDLE with the FIFO flushed. No done_o is issued.
- Latency:
  - Row pushed in cycle N → aw_valid_o earliest in N+1.
  - Command accepted in cycle N → drain_req_o in N+1.
  - Final handshake in cycle N → done_o in N+1.

Test Plan:
- Basic drain: command base=0x1000; 16 rows, one per cycle, idx 0..15; aw_ready_i held 1 → drain_req_o pulses once; 16 writes at 0x1000,0x1100,…,0x1F00 with the matching data; done_o is a single pulse; err_o=0.
- Backpressure: aw_ready_i low for the first 20 cycles while all 16 rows arrive → FIFO reaches full with no drop; 16 writes then complete in order; aw signals stable while stalled; err_o=0.
- Out-of-order indices: rows arrive with idx 15,14,…,0 → writes follow arrival order with addr = base+idx*256 (first write 0x1F00); done_o after the 16th handshake.
- Protocol errors: row_valid_i pulsed while IDLE → err_o=1 and no AW activity. Separately, a 17th row during DRAIN → dropped and err_o=1.
- Command hold-off and wrap: second command presented during DRAIN → cmd_ready_o=0 until after done_o, then accepted. Base=0xFFFF_FFFF_FFFF_FF00 with idx 1 → aw_addr_o=0x0.
- Reset mid-drain: assert rst_n low after 5 writes → all outputs 0 and state IDLE. A new command then completes a fresh 16-row drain correctly.
